// File: rtl/mips_write_monitor_pkg.sv
// rtl/mips_write_monitor_pkg.sv - shared state and fail-code definitions for the write monitor
//
// Purpose: checker state encoding and fail_code values, shared by the monitor
// top level and its bench.
// Ports: none (package).
package mips_write_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_PASS  = 3'd2,
    ST_FAIL  = 3'd3,
    ST_TMO   = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_DATA = 2'b01;
  localparam logic [1:0] FC_ADR  = 2'b10;
  localparam logic [1:0] FC_TMO  = 2'b11;

endpackage

// File: rtl/mips_write_monitor_exp_table.sv
// rtl/mips_write_monitor_exp_table.sv - expected (adr,data) write table
//
// Purpose: DEPTH x (2*WIDTH) register file of expected writes. It has one
// synchronous write port and one asynchronous read port. The contents are
// deliberately not reset.
// Ports:
//   clk            clock
//   we             write enable (gated by the caller while a check is running)
//   widx           write index
//   wadr, wdata    expected address / data to store
//   ridx           read index (the current match count)
//   radr, rdata    expected address / data at ridx
module mips_write_monitor_exp_table #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [WIDTH-1:0]         wadr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [WIDTH-1:0]         radr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] adr_mem  [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      adr_mem[widx]  <= wadr;
      data_mem[widx] <= wdata;
    end
  end

  assign radr  = adr_mem[ridx];
  assign rdata = data_mem[ridx];

endmodule

// File: rtl/mips_write_monitor.sv
// rtl/mips_write_monitor.sv - loadable-table checker for the mips_mem write interface
//
// Purpose: compares tapped memory writes against a table of expected
// (adr,data) pairs. It reports the verdict as pass, data mismatch, address
// mismatch or timeout, and captures the offending write.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   ld_we, ld_idx, ld_adr, ld_data  table load port (ignored while ARMED)
//   num_exp                       entries to check, sampled on start (clamped to DEPTH)
//   start                         clear results and arm the check
//   memwrite, adr, writedata      tapped memory write port
//   done, pass                    verdict flags
//   fail_code                     00 none, 01 data, 10 adr, 11 timeout
//   match_cnt                     entries matched so far
//   fail_adr, fail_data           captured offending write (0 on timeout)
module mips_write_monitor
  import mips_write_monitor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000,
  parameter int MODE    = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [WIDTH-1:0]         ld_adr,
  input  logic [WIDTH-1:0]         ld_data,
  input  logic [$clog2(DEPTH):0]   num_exp,
  input  logic                     start,
  input  logic                     memwrite,
  input  logic [WIDTH-1:0]         adr,
  input  logic [WIDTH-1:0]         writedata,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               fail_code,
  output logic [$clog2(DEPTH):0]   match_cnt,
  output logic [WIDTH-1:0]         fail_adr,
  output logic [WIDTH-1:0]         fail_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int NW = IW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_next;
  logic [NW-1:0]   num_lat;
  logic [NW-1:0]   num_clamped;
  logic [NW-1:0]   match_inc;
  logic [CW-1:0]   cyc_cnt;
  logic [WIDTH-1:0] exp_adr, exp_data;
  logic            ev_match, ev_data, ev_adr, ev_tmo;

  mips_write_monitor_exp_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk   (clk),
    .we    (ld_we && (state != ST_ARMED)),
    .widx  (ld_idx),
    .wadr  (ld_adr),
    .wdata (ld_data),
    .ridx  (match_cnt[IW-1:0]),
    .radr  (exp_adr),
    .rdata (exp_data)
  );

  assign num_clamped = (num_exp > NW'(DEPTH)) ? NW'(DEPTH) : num_exp;
  assign match_inc   = match_cnt + NW'(1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state and event decode. The branch order inside ARMED sets the
  // priority: start, an empty table, a checked write, then the timeout.
  always_comb begin
    state_next = state;
    ev_match   = 1'b0;
    ev_data    = 1'b0;
    ev_adr     = 1'b0;
    ev_tmo     = 1'b0;
    case (state)
      ST_IDLE, ST_PASS, ST_FAIL, ST_TMO: begin
        if (start) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (start) begin
          state_next = ST_ARMED;
        end else if (match_cnt >= num_lat) begin
          state_next = ST_PASS;
        end else if (memwrite && (adr == exp_adr) && (writedata == exp_data)) begin
          ev_match = 1'b1;
          if (match_inc == num_lat) state_next = ST_PASS;
        end else if (memwrite && (adr == exp_adr)) begin
          ev_data    = 1'b1;
          state_next = ST_FAIL;
        end else if (memwrite && (MODE == 0)) begin
          ev_adr     = 1'b1;
          state_next = ST_FAIL;
        end else if (cyc_cnt == CW'(TIMEOUT)) begin
          ev_tmo     = 1'b1;
          state_next = ST_TMO;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counters and captured results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_lat   <= '0;
      cyc_cnt   <= '0;
      match_cnt <= '0;
      fail_code <= FC_NONE;
      fail_adr  <= '0;
      fail_data <= '0;
    end else if (start) begin
      num_lat   <= num_clamped;
      cyc_cnt   <= '0;
      match_cnt <= '0;
      fail_code <= FC_NONE;
      fail_adr  <= '0;
      fail_data <= '0;
    end else if (state == ST_ARMED) begin
      // Saturates at TIMEOUT so a long-armed check can never wrap back.
      if (cyc_cnt != CW'(TIMEOUT)) cyc_cnt <= cyc_cnt + CW'(1);
      if (ev_match) match_cnt <= match_inc;
      if (ev_data || ev_adr) begin
        fail_code <= ev_data ? FC_DATA : FC_ADR;
        fail_adr  <= adr;
        fail_data <= writedata;
      end
      if (ev_tmo) fail_code <= FC_TMO;
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    done = 1'b0;
    pass = 1'b0;
    case (state)
      ST_PASS:         begin done = 1'b1; pass = 1'b1; end
      ST_FAIL, ST_TMO: done = 1'b1;
      default:         ;
    endcase
  end

endmodule
